// File: rtl/spi_flash_arbiter_if.sv
// Request/response bundle between the fetch and data
// requesters and the shared SPI flash arbiter.
interface spi_flash_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic [15:0] d_addr;
  logic [7:0]  d_rdata;
  logic        d_done;

  modport master (
    output i_req, i_addr, d_req, d_addr,
    input  i_rdata, i_done, d_rdata, d_done
  );

  modport slave (
    input  i_req, i_addr, d_req, d_addr,
    output i_rdata, i_done, d_rdata, d_done
  );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Round-robin arbiter sharing one SPI flash (mode 0 read)
// between an instruction-fetch port and a data-read port.
module spi_flash_arbiter #(
  parameter int         CLK_DIV  = 1,
  parameter logic [7:0] READ_CMD = 8'h03
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_flash_arbiter_if.slave bus,
  output logic               busy,
  output logic               grant_d,
  output logic               spi_cs_n,
  output logic               spi_sclk,
  output logic               spi_mosi,
  input  logic               spi_miso
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    READ = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  state_t      state_nx;
  logic [7:0]  div_cnt;
  logic        phase;
  logic [4:0]  bit_cnt;
  logic [23:0] addr_q;
  logic [15:0] rx_q;
  logic        bit_end;
  logic        last_bit;
  logic        any_req;
  logic        win_d;
  logic        shifting;

  assign bit_end  = phase && (div_cnt == DIV_LAST);
  assign any_req  = bus.i_req || bus.d_req;
  assign win_d    = bus.d_req && (!bus.i_req || !grant_d);
  assign shifting = (state == CMD) || (state == ADDR) ||
                    (state == READ);

  // Last bit of the current shifting phase
  always_comb begin
    last_bit = 1'b0;
    unique case (state)
      CMD:     last_bit = bit_cnt == 5'd7;
      ADDR:    last_bit = bit_cnt == 5'd23;
      READ:    last_bit = bit_cnt == (grant_d ? 5'd7 : 5'd15);
      default: last_bit = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (any_req) state_nx = CMD;
      CMD:  if (bit_end && last_bit) state_nx = ADDR;
      ADDR: if (bit_end && last_bit) state_nx = READ;
      READ: if (bit_end && last_bit) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // SPI pin and status outputs decoded from state
  always_comb begin
    busy     = state != IDLE;
    spi_cs_n = !shifting;
    spi_sclk = shifting && phase;
    spi_mosi = 1'b0;
    unique case (state)
      CMD:     spi_mosi = READ_CMD[~bit_cnt[2:0]];
      ADDR:    spi_mosi = addr_q[5'd23 - bit_cnt];
      default: spi_mosi = 1'b0;
    endcase
  end

  // Grant, bit timing, receive shifter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_d     <= 1'b1;
      div_cnt     <= '0;
      phase       <= 1'b0;
      bit_cnt     <= '0;
      addr_q      <= '0;
      rx_q        <= '0;
      bus.i_rdata <= '0;
      bus.d_rdata <= '0;
      bus.i_done  <= 1'b0;
      bus.d_done  <= 1'b0;
    end else begin
      bus.i_done <= 1'b0;
      bus.d_done <= 1'b0;
      if (state == IDLE) begin
        div_cnt <= '0;
        phase   <= 1'b0;
        bit_cnt <= '0;
        if (any_req) begin
          grant_d <= win_d;
          addr_q  <= win_d ? {8'b0, bus.d_addr}
                           : {7'b0, bus.i_addr, 1'b0};
        end
      end else if (shifting) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          phase   <= !phase;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
        if (bit_end) begin
          bit_cnt <= last_bit ? 5'd0 : bit_cnt + 5'd1;
          if (state == READ) rx_q <= {rx_q[14:0], spi_miso};
          if (state == READ && last_bit) begin
            if (grant_d) begin
              bus.d_rdata <= {rx_q[6:0], spi_miso};
              bus.d_done  <= 1'b1;
            end else begin
              bus.i_rdata <= {rx_q[14:0], spi_miso};
              bus.i_done  <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
